// File: rtl/rr_encoder32_pkg.sv
// rtl/rr_encoder32_pkg.sv - shared sizes and state encoding for the round-robin encoder
package rr_encoder32_pkg;

  localparam int N     = 32;
  localparam int IDX_W = 5;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

endpackage

// File: rtl/rr_encoder32_if.sv
// rtl/rr_encoder32_if.sv - request/grant handshake bundle between requesters and the encoder
interface rr_encoder32_if;
  import rr_encoder32_pkg::*;

  logic             enable;
  logic [N-1:0]     req;
  logic             ack;
  logic             valid;
  logic [IDX_W-1:0] index;
  logic [N-1:0]     grant;
  logic             any_req;

  modport master (
    output enable, req, ack,
    input  valid, index, grant, any_req
  );

  modport slave (
    input  enable, req, ack,
    output valid, index, grant, any_req
  );

endinterface

// File: rtl/rr_encoder32_pri_enc32.sv
// rtl/rr_encoder32_pri_enc32.sv - first set bit at or above start, wrapping 31 -> 0
module pri_enc32
  import rr_encoder32_pkg::*;
(
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] start,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  logic [2*N-1:0]   doubled;
  logic [N-1:0]     rotated;
  logic [IDX_W-1:0] lsb;

  // Rotating right by start puts the scan origin at bit 0; the wrap is free in 5-bit add.
  assign doubled = {req, req} >> start;
  assign rotated = doubled[N-1:0];

  always_comb begin
    lsb = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rotated[i]) begin
        lsb = i[IDX_W-1:0];
      end
    end
  end

  assign found = |req;
  assign idx   = lsb + start;

endmodule

// File: rtl/rr_encoder32.sv
// rtl/rr_encoder32.sv - round-robin 32-to-5 encoder with held grant and valid/ack handshake
module rr_encoder32
  import rr_encoder32_pkg::*;
(
  input  logic           clock,
  input  logic           reset,
  rr_encoder32_if.slave  bus
);

  state_t           state, state_nx;
  logic [IDX_W-1:0] pointer, pointer_nx;
  logic [IDX_W-1:0] index_q, index_nx;
  logic [IDX_W-1:0] start;
  logic [N-1:0]     gated_req;
  logic             found;
  logic [IDX_W-1:0] pick;

  // req is masked so an undriven bus cannot leak into the selection while disabled.
  assign gated_req = bus.enable ? bus.req : '0;

  // On ack the scan starts just past the acknowledged source, i.e. the updated pointer.
  assign start = (state == GRANT) ? (index_q + 1'b1) : pointer;

  pri_enc32 u_pri_enc (
    .req   (gated_req),
    .start (start),
    .found (found),
    .idx   (pick)
  );

  always_comb begin
    state_nx   = state;
    pointer_nx = pointer;
    index_nx   = index_q;
    case (state)
      IDLE: begin
        if (found) begin
          index_nx = pick;
          state_nx = GRANT;
        end else begin
          index_nx = '0;
        end
      end
      GRANT: begin
        if (bus.ack) begin
          pointer_nx = index_q + 1'b1;
          if (found) begin
            index_nx = pick;
          end else begin
            index_nx = '0;
            state_nx = IDLE;
          end
        end
      end
      default: begin
        state_nx = IDLE;
        index_nx = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      pointer <= '0;
      index_q <= '0;
    end else begin
      state   <= state_nx;
      pointer <= pointer_nx;
      index_q <= index_nx;
    end
  end

  assign bus.valid   = (state == GRANT);
  assign bus.index   = index_q;
  assign bus.grant   = bus.valid ? (N'(1) << index_q) : '0;
  assign bus.any_req = |bus.req;

endmodule

// File: doc/rr_encoder32.md
Name: rr_encoder32

Overview:
- Sequential encoder for 32 request lines; the inverse direction of the 5-bit-select to 32-bit one-hot decoder used for register-file and bus enables.
- Selects one active requester per grant using round-robin priority.
- Presents the selection as a registered 5-bit index and a matching one-hot grant.
- Holds each grant with a valid/ack handshake so the selected source can drive the shared tristate bus for as many cycles as it needs.

Parameters:
- N, 32, number of request lines (fixed at 32 for this block).
- IDX_W, 5, index width (log2 N).

Ports:
- clock  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- enable  input  1  permits a new grant to be issued.
- req  input  32  request lines; bit i high = source i requests.
- ack  input  1  consumer has finished with the current grant.
- valid  output  1  a grant is held.
- index  output  5  encoded number of the granted source.
- grant  output  32  one-hot grant (1 << index) when valid; all zero otherwise.
- any_req  output  1  combinational OR of req.

Behaviour:
- Reset (reset = 0, asynchronous): state IDLE; valid = 0; index = 0; grant = 0; pointer = 0. Outputs clear immediately, including mid-grant. The first edge after release behaves as IDLE.
- State IDLE:
  - If enable = 1 and req != 0, choose the first set bit scanning upward from pointer, wrapping 31 -> 0.
  - On that edge: register index, set valid = 1, move to GRANT.
  - Latency is one clock from req/enable sampled to valid high.
  - If enable = 0 or req = 0, remain in IDLE with outputs cleared.
- State GRANT:
  - index, grant and valid hold stable until ack = 1 is sampled.
  - Grants are never revoked: dropping req[index], deasserting enable, or new higher-priority requests do not change the outputs.
- Ack in GRANT:
  - pointer <= (index + 1) mod 32; 31 wraps to 0.
  - If enable = 1 and req != 0 in the same cycle, issue the next grant on that edge using the updated pointer. valid stays 1 (no bubble) and index changes.
  - Otherwise return to IDLE with valid = 0 and grant = 0.
- The just-acknowledged source has the lowest priority in the re-selection even if its req is still high. It is re-granted only if it is the sole requester.
- ack sampled in IDLE is ignored.
- Pointer changes only on an acknowledged grant, never on reset release or while idle.
- grant is combinational from the registered valid and index (equivalently decoder(index, valid)), so it is glitch-free relative to the clock.
- Fairness: with all 32 requests held high continuously, indices are granted in strict order pointer, pointer+1, ...
- X-safety: req is evaluated only when enable = 1.

Decomposition:
- Shared package: N, IDX_W, and the state encoding (IDLE = 0, GRANT = 1).
- Sub-module pri_enc32 (combinational): inputs req[31:0] and start[4:0]; outputs found and idx[4:0], the first set bit at or above start with wrap-around.
  - Implement as a rotate by start, a fixed lowest-set-bit encode, then an add of start mod 32.
  - rr_encoder32 holds only the state, pointer and output registers around it.

Test Plan:
- Reset release, req = 32'h0000_0010, enable = 1 -> next edge: valid = 1, index = 4, grant = 32'h10. Hold ack = 0 for 5 cycles -> outputs unchanged.
- req = 32'h8000_0001, pointer 0: grant index 0; ack with req unchanged -> same edge index = 31 (valid stays 1); ack again -> index = 0 (pointer wrapped from 31 to 0).
- req = 32'hFFFF_FFFF, ack held high each cycle after first grant -> indices 0, 1, 2, ..., 31, 0 on consecutive cycles, valid never drops.
- During a grant of index 7: drop req[7], raise req[2], set enable = 0 -> index stays 7 until ack. After ack with enable = 0 -> valid = 0, grant = 0, state IDLE.
- Assert reset low mid-grant (index 12) between clock edges -> valid, index and grant go to 0 immediately. After release with req = 32'h1000 -> index 12 granted (pointer back to 0).
- req = 0, enable = 1, ack pulsed -> valid stays 0; any_req = 0. Set req[20] -> any_req = 1 same cycle, valid = 1 and index = 20 one edge later.
